mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS core; it is the producer side of the ALU `alu_op` interface.
- Decodes `opcode`/`funct` from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives every datapath enable/select and the 3-bit `alu_op` consumed by the ALU.
- Moore-style: all outputs decode from the registered state only, plus `zero` for the PC enable.

Parameters:
- SUPPORT_BNE, 1, when 1 opcode 6'b000101 (bne) is legal; when 0 it is treated as illegal.
- STATE_W, 4, width of the state register and `state_dbg` port.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instr[31:26] from IR; valid from DECODE onward.
- funct  in  6  instr[5:0] from IR.
- zero  in  1  datapath zero flag: ALU result == 0 in the current cycle.
- pc_en  out  1  PC load enable.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- pc_src  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_op  out  3  ALU operation: bit2 = invert B, [1:0] = 10 add, 00 and, 01 or, 11 slt.
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct.
- state_dbg  out  STATE_W  current state, for the bench.

Behaviour:
- ALU codes: ADD = 3'b010, SUB = 3'b110, AND = 3'b000, OR = 3'b001, SLT = 3'b111.
- Default output value for every state: all outputs 0 unless listed below, so `alu_op` defaults to AND.
- While `reset` is high: every output is forced to 0 combinationally. On the first edge with reset high, state becomes FETCH.
- Reset mid-instruction abandons the instruction; no `reg_write` or `mem_write` is asserted while reset is high.

State actions and transitions:
- FETCH: `ir_write`=1, `pc_en`=1, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD, `pc_src`=00. -> DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=ADD (branch target into ALUOut). Next state by opcode:
  - 000000 -> RTYPE_EX
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQ
  - 000101 -> BNE, if SUPPORT_BNE
  - 001000 -> ADDI_EX
  - 000010 -> JUMP
  - otherwise -> FETCH with `illegal`=1 this cycle.
- RTYPE_EX: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from `funct`:
  - 100000 -> ADD, 100010 -> SUB, 100100 -> AND, 100101 -> OR, 101010 -> SLT.
  - Legal funct -> ALU_WB.
  - Other funct -> FETCH, `illegal`=1, `alu_op`=AND; no register write.
- ALU_WB: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1. -> FETCH.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=ADD. lw -> MEMRD; sw -> MEMWR.
- MEMRD: `i_or_d`=1. -> MEMWB.
- MEMWB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1. -> FETCH.
- MEMWR: `i_or_d`=1, `mem_write`=1. -> FETCH.
- BEQ / BNE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=SUB, `pc_src`=01.
  - BEQ: `pc_en` = `zero`. BNE: `pc_en` = !`zero`. -> FETCH.
- ADDI_EX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=ADD. -> ADDI_WB.
- ADDI_WB: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1. -> FETCH.
- JUMP: `pc_src`=10, `pc_en`=1. -> FETCH.

Latency in cycles, FETCH inclusive:
- R-type 4, lw 5, sw 4, beq/bne 3, addi 4, j 3, illegal opcode 2, illegal funct 3.

Invariants:
- `opcode`/`funct` are sampled only in DECODE and RTYPE_EX; changes in other states have no effect.
- `zero` affects only `pc_en` in BEQ/BNE.
- No state asserts both `reg_write` and `mem_write`.
- Unused state encodings -> FETCH on the next edge, `illegal`=1.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset. First cycle after release: `state_dbg`=FETCH, `ir_write`=1, `pc_en`=1, `alu_op`=3'b010, `alu_src_b`=01.
- opcode 000000, funct 100010 -> RTYPE_EX shows `alu_op`=3'b110; next cycle `reg_write`=1, `reg_dst`=1; back in FETCH at cycle 5.
  - Repeat for funct 100000/100100/100101/101010 -> `alu_op` 010/000/001/111.
- opcode 100011 (lw) -> MEMRD `i_or_d`=1; MEMWB `mem_to_reg`=1, `reg_write`=1; 5-cycle instruction.
- opcode 101011 (sw) -> `mem_write`=1 for exactly one cycle; `reg_write` never 1; 4-cycle instruction.
- beq with `zero`=1 -> `pc_en`=1, `pc_src`=01 in BEQ. beq with `zero`=0 -> `pc_en`=0.
  - bne with SUPPORT_BNE=1 gives the inverse; with SUPPORT_BNE=0, opcode 000101 gives `illegal` pulse in DECODE.
- opcode 111111 -> `illegal`=1 for one cycle, FETCH next.
- funct 000000 on R-type -> `illegal` in RTYPE_EX, no `reg_write`.
- Reset asserted in MEMWR -> `mem_write` drops to 0 the same cycle; FETCH after release.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core.
// Sequences fetch / decode / execute / memory / writeback and drives every
// datapath enable and select plus the 3-bit alu_op consumed by the ALU.
module mips_multicycle_ctrl #(
    parameter bit SUPPORT_BNE = 1'b1,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_en,
    output logic               i_or_d,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [2:0]         alu_op,
    output logic               illegal,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_RTYPE   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_ALU_WB  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMADR  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMRD   = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_MEMWB   = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_MEMWR   = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BEQ     = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BNE     = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_ADDI_EX = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_ADDI_WB = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_JUMP    = STATE_W'(12);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic               mem_is_sw;
    logic               funct_ok;
    logic [2:0]         funct_op;

    // R-type funct decode: legal flag and the matching ALU code
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        funct_ok = 1'b1;
        funct_op = ALU_AND;
        case (funct)
            6'b100000: funct_op = ALU_ADD;
            6'b100010: funct_op = ALU_SUB;
            6'b100100: funct_op = ALU_AND;
            6'b100101: funct_op = ALU_OR;
            6'b101010: funct_op = ALU_SLT;
            default:   funct_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Remember lw vs sw at decode so MEMADR does not depend on opcode later
    always_ff @(posedge clk) begin
        if (reset)                  mem_is_sw <= 1'b0;
        else if (state == S_DECODE) mem_is_sw <= (opcode == OP_SW);
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = S_RTYPE;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_BNE:       state_next = SUPPORT_BNE ? S_BNE : S_FETCH;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_RTYPE:   state_next = funct_ok ? S_ALU_WB : S_FETCH;
            S_MEMADR:  state_next = mem_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = S_MEMWB;
            S_ADDI_EX: state_next = S_ADDI_WB;
            default:   state_next = S_FETCH;
        endcase
    end

    // Output decode from the registered state (zero only gates branch pc_en)
    always_comb begin
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = ALU_AND;
        illegal    = 1'b0;
        state_dbg  = '0;
        if (!reset) begin
            state_dbg = state;
            case (state)
                S_FETCH: begin
                    ir_write  = 1'b1;
                    pc_en     = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = ALU_ADD;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = ALU_ADD;
                    case (opcode)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
                        OP_BNE:  illegal = !SUPPORT_BNE;
                        default: illegal = 1'b1;
                    endcase
                end
                S_RTYPE: begin
                    alu_src_a = 1'b1;
                    alu_op    = funct_op;
                    illegal   = !funct_ok;
                end
                S_ALU_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_MEMADR, S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = ALU_ADD;
                end
                S_MEMRD: i_or_d = 1'b1;
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                S_BEQ, S_BNE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = 2'b01;
                    pc_en     = (state == S_BEQ) ? zero : !zero;
                end
                S_ADDI_WB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks every instruction class
// through its state sequence and compares the full control word each cycle.
module tb_mips_multicycle_ctrl;

    // Control word: {pc_en,i_or_d,mem_write,ir_write}, {reg_dst,mem_to_reg,reg_write,alu_src_a},
    //               alu_src_b, pc_src, alu_op, illegal
    localparam logic [15:0] E_ZERO      = 16'h0000;
    localparam logic [15:0] E_FETCH     = {4'b1001, 4'b0000, 2'b01, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_DECODE    = {4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_DEC_ILL   = {4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010, 1'b1};
    localparam logic [15:0] E_RTYPE_ILL = {4'b0000, 4'b0001, 2'b00, 2'b00, 3'b000, 1'b1};
    localparam logic [15:0] E_ALU_WB    = {4'b0000, 4'b1010, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] E_MEMADR    = {4'b0000, 4'b0001, 2'b10, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_MEMRD     = {4'b0100, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] E_MEMWB     = {4'b0000, 4'b0110, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] E_MEMWR     = {4'b0110, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] E_ADDI_WB   = {4'b0000, 4'b0010, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] E_JUMP      = {4'b1000, 4'b0000, 2'b00, 2'b10, 3'b000, 1'b0};

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_RTYPE = 4'd2, S_ALU_WB = 4'd3,
                           S_MEMADR = 4'd4, S_MEMRD = 4'd5, S_MEMWB = 4'd6, S_MEMWR = 4'd7,
                           S_BEQ = 4'd8, S_BNE = 4'd9, S_ADDI_EX = 4'd10, S_ADDI_WB = 4'd11,
                           S_JUMP = 4'd12;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic       illegal;
    logic [3:0] state_dbg;

    // Second instance with bne disabled, only illegal/state observed
    logic       nb_pc_en, nb_i_or_d, nb_mem_write, nb_ir_write, nb_reg_dst, nb_mem_to_reg;
    logic       nb_reg_write, nb_alu_src_a, nb_illegal;
    logic [1:0] nb_alu_src_b, nb_pc_src;
    logic [2:0] nb_alu_op;
    logic [3:0] nb_state_dbg;

    int errors = 0;
    int checks = 0;

    mips_multicycle_ctrl #(.SUPPORT_BNE(1'b1), .STATE_W(4)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_op(alu_op), .illegal(illegal), .state_dbg(state_dbg)
    );

    mips_multicycle_ctrl #(.SUPPORT_BNE(1'b0), .STATE_W(4)) u_dut_nobne (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(nb_pc_en), .i_or_d(nb_i_or_d), .mem_write(nb_mem_write), .ir_write(nb_ir_write),
        .reg_dst(nb_reg_dst), .mem_to_reg(nb_mem_to_reg), .reg_write(nb_reg_write),
        .alu_src_a(nb_alu_src_a), .alu_src_b(nb_alu_src_b), .pc_src(nb_pc_src),
        .alu_op(nb_alu_op), .illegal(nb_illegal), .state_dbg(nb_state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] e_rtype(input logic [2:0] op);
        return {4'b0000, 4'b0001, 2'b00, 2'b00, op, 1'b0};
    endfunction

    function automatic logic [15:0] e_branch(input logic taken);
        return {taken, 3'b000, 4'b0001, 2'b00, 2'b01, 3'b110, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] exp_ctrl, input logic [3:0] exp_state);
        check({tag, ".ctrl"}, 32'({pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
              reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal}), 32'(exp_ctrl));
        check({tag, ".state"}, 32'(state_dbg), 32'(exp_state));
    endtask

    logic [5:0] f_tab [4] = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] a_tab [4] = '{3'b010, 3'b000, 3'b001, 3'b111};

    initial begin
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b000000;
        zero   = 1'b0;

        // Reset held for three edges: all outputs zero
        repeat (3) begin
            tick();
            chk("reset", E_ZERO, 4'd0);
        end
        reset = 1'b0;
        #1;
        chk("fetch_after_reset", E_FETCH, S_FETCH);

        // R-type sub, 4-cycle instruction
        opcode = 6'b000000;
        funct  = 6'b100010;
        tick(); chk("sub.decode", E_DECODE, S_DECODE);
        tick(); chk("sub.ex", e_rtype(3'b110), S_RTYPE);
        tick(); chk("sub.wb", E_ALU_WB, S_ALU_WB);
        tick(); chk("sub.fetch", E_FETCH, S_FETCH);

        // Remaining R-type funct codes
        for (int i = 0; i < 4; i++) begin
            funct = f_tab[i];
            tick(); chk("rtype.decode", E_DECODE, S_DECODE);
            tick(); chk("rtype.ex", e_rtype(a_tab[i]), S_RTYPE);
            tick(); chk("rtype.wb", E_ALU_WB, S_ALU_WB);
            tick(); chk("rtype.fetch", E_FETCH, S_FETCH);
        end

        // lw, 5 cycles; opcode changed in MEMADR must not matter
        opcode = 6'b100011;
        tick(); chk("lw.decode", E_DECODE, S_DECODE);
        tick(); chk("lw.memadr", E_MEMADR, S_MEMADR);
        opcode = 6'b101011;
        tick(); chk("lw.memrd", E_MEMRD, S_MEMRD);
        tick(); chk("lw.memwb", E_MEMWB, S_MEMWB);
        tick(); chk("lw.fetch", E_FETCH, S_FETCH);

        // sw, 4 cycles
        opcode = 6'b101011;
        tick(); chk("sw.decode", E_DECODE, S_DECODE);
        tick(); chk("sw.memadr", E_MEMADR, S_MEMADR);
        tick(); chk("sw.memwr", E_MEMWR, S_MEMWR);
        tick(); chk("sw.fetch", E_FETCH, S_FETCH);

        // beq taken / not taken; zero high in DECODE has no effect
        opcode = 6'b000100;
        zero   = 1'b1;
        tick(); chk("beq1.decode", E_DECODE, S_DECODE);
        tick(); chk("beq1.br", e_branch(1'b1), S_BEQ);
        tick(); chk("beq1.fetch", E_FETCH, S_FETCH);
        zero = 1'b0;
        tick(); chk("beq0.decode", E_DECODE, S_DECODE);
        tick(); chk("beq0.br", e_branch(1'b0), S_BEQ);
        tick(); chk("beq0.fetch", E_FETCH, S_FETCH);

        // bne: inverse; disabled instance flags illegal in DECODE
        opcode = 6'b000101;
        zero   = 1'b0;
        tick(); chk("bne0.decode", E_DECODE, S_DECODE);
        check("nobne.illegal", 32'(nb_illegal), 32'd1);
        check("nobne.decode_state", 32'(nb_state_dbg), 32'(S_DECODE));
        tick(); chk("bne0.br", e_branch(1'b1), S_BNE);
        check("nobne.back_to_fetch", 32'(nb_state_dbg), 32'(S_FETCH));
        check("nobne.illegal_cleared", 32'(nb_illegal), 32'd0);
        tick(); chk("bne0.fetch", E_FETCH, S_FETCH);
        zero = 1'b1;
        tick(); chk("bne1.decode", E_DECODE, S_DECODE);
        tick(); chk("bne1.br", e_branch(1'b0), S_BNE);
        tick(); chk("bne1.fetch", E_FETCH, S_FETCH);
        zero = 1'b0;

        // Illegal opcode: 2-cycle, one-cycle pulse
        opcode = 6'b111111;
        tick(); chk("illop.decode", E_DEC_ILL, S_DECODE);
        tick(); chk("illop.fetch", E_FETCH, S_FETCH);

        // Illegal funct: 3-cycle, no register write
        opcode = 6'b000000;
        funct  = 6'b000000;
        tick(); chk("illfn.decode", E_DECODE, S_DECODE);
        tick(); chk("illfn.ex", E_RTYPE_ILL, S_RTYPE);
        tick(); chk("illfn.fetch", E_FETCH, S_FETCH);

        // addi, 4 cycles
        opcode = 6'b001000;
        tick(); chk("addi.decode", E_DECODE, S_DECODE);
        tick(); chk("addi.ex", E_MEMADR, S_ADDI_EX);
        tick(); chk("addi.wb", E_ADDI_WB, S_ADDI_WB);
        tick(); chk("addi.fetch", E_FETCH, S_FETCH);

        // j, 3 cycles
        opcode = 6'b000010;
        tick(); chk("j.decode", E_DECODE, S_DECODE);
        tick(); chk("j.jump", E_JUMP, S_JUMP);
        tick(); chk("j.fetch", E_FETCH, S_FETCH);

        // Reset during MEMWR drops mem_write in the same cycle
        opcode = 6'b101011;
        tick(); chk("rst.decode", E_DECODE, S_DECODE);
        tick(); chk("rst.memadr", E_MEMADR, S_MEMADR);
        tick(); chk("rst.memwr", E_MEMWR, S_MEMWR);
        reset = 1'b1;
        #1;
        chk("rst.forced", E_ZERO, 4'd0);
        tick(); chk("rst.held", E_ZERO, 4'd0);
        reset = 1'b0;
        #1;
        chk("rst.release", E_FETCH, S_FETCH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
